matrix_result_collector: RTL and testbench

MATRIX_RESULT_COLLECTOR -- requirements
Module: matrix_result_collector

---
 rtl/matrix_pkg.sv | 28 ++
 rtl/result_ram.sv | 53 +++++
 rtl/matrix_result_collector.sv | 123 ++++++++++++
 tb/tb_matrix_result_collector.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// -----------------------------------------------------------------------------
// matrix_pkg
// Shared definitions for the ALU matrix stage and the result collector:
// default matrix dimension and element width, the collector FSM state
// encoding, and a width helper for address/index ports.
// -----------------------------------------------------------------------------
package matrix_pkg;

  localparam int DIM_DEF = 4;
  localparam int W_DEF   = 32;

  // Fixed encodings so other blocks and debug tooling see stable codes.
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CAPTURE = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    CAPTURE = ST_CAPTURE,
    DONE    = ST_DONE
  } state_e;

  // ceil(log2(n)), never below 1 so degenerate sizes still give a legal port.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/result_ram.sv
// -----------------------------------------------------------------------------
// result_ram
// DEPTH x W result buffer: one synchronous write port, one registered read
// port. A same-cycle read and write to one address returns the old data.
// Reads beyond DEPTH-1 return 0. Reset clears only the read register;
// the array contents survive reset.
//
// Ports
//   clk      : rising-edge clock
//   reset    : synchronous active-low reset (read register only)
//   we       : write enable
//   wr_addr  : write address
//   wr_data  : write data
//   rd_addr  : read address
//   rd_data  : registered read data (1-cycle latency)
// -----------------------------------------------------------------------------
module result_ram #(
  parameter int DEPTH = 16,
  parameter int W     = 32,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);

  logic [W-1:0] mem [DEPTH];
  logic         rd_in_range;

  // Extra bit keeps the compare correct when DEPTH is exactly 2**AW.
  assign rd_in_range = ({1'b0, rd_addr} < (AW+1)'(DEPTH));

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_data <= '0;
    end else if (rd_in_range) begin
      rd_data <= mem[rd_addr];
    end else begin
      rd_data <= '0;
    end
  end

endmodule

// File: rtl/matrix_result_collector.sv
// -----------------------------------------------------------------------------
// matrix_result_collector
// Captures one DIM x DIM result matrix, streamed row-major from the ALU
// matrix stage, into result_ram and exposes it through a registered read
// port. Elements arriving outside a capture set a sticky overflow flag.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | waiting for start; stray elements set overflow
//   CAPTURE | storing elements at row*DIM+col on each ele_valid
//   DONE    | single-cycle done pulse, then back to IDLE
//
// Ports
//   clk       : rising-edge clock
//   reset     : synchronous active-low reset (beats start/ele_valid)
//   start     : arm capture of one matrix (honoured in IDLE only)
//   ele_valid : eleOut carries a valid element this cycle
//   eleOut    : result element
//   rd_addr   : buffer read address, row*DIM+col
//   rd_data   : registered read data
//   busy      : high in CAPTURE
//   done      : one-cycle pulse after the last element is stored
//   row, col  : current write position
//   overflow  : sticky, element seen while not capturing
// -----------------------------------------------------------------------------
module matrix_result_collector
  import matrix_pkg::*;
#(
  parameter int DIM = DIM_DEF,
  parameter int W   = W_DEF,
  parameter int AW  = clog2_min1(DIM*DIM),
  parameter int RW  = clog2_min1(DIM)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          ele_valid,
  input  logic [W-1:0]  eleOut,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data,
  output logic          busy,
  output logic          done,
  output logic [RW-1:0] row,
  output logic [RW-1:0] col,
  output logic          overflow
);

  localparam int            DEPTH = DIM * DIM;
  localparam logic [RW-1:0] LAST  = RW'(DIM - 1);

  state_e        state;
  logic          we;
  logic [AW-1:0] wr_addr;

  assign busy    = (state == CAPTURE);
  assign done    = (state == DONE);
  // Gating with reset keeps an element coincident with reset out of the RAM.
  assign we      = reset && busy && ele_valid;
  assign wr_addr = AW'(row) * AW'(DIM) + AW'(col);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      row      <= '0;
      col      <= '0;
      overflow <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          // start wins over a coincident element: the element is dropped
          // and overflow is cleared rather than set.
          if (start) begin
            row      <= '0;
            col      <= '0;
            overflow <= 1'b0;
            state    <= CAPTURE;
          end else if (ele_valid) begin
            overflow <= 1'b1;
          end
        end
        CAPTURE: begin
          if (ele_valid) begin
            if (col == LAST) begin
              col <= '0;
              if (row == LAST) begin
                row   <= '0;
                state <= DONE;
              end else begin
                row <= row + 1'b1;
              end
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        DONE: begin
          if (ele_valid) begin
            overflow <= 1'b1;
          end
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  result_ram #(
    .DEPTH (DEPTH),
    .W     (W),
    .AW    (AW)
  ) u_result_ram (
    .clk     (clk),
    .reset   (reset),
    .we      (we),
    .wr_addr (wr_addr),
    .wr_data (eleOut),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_matrix_result_collector.sv
module tb_matrix_result_collector;

  localparam int DIM = 4;
  localparam int W   = 32;
  localparam int N   = DIM * DIM;
  localparam int AW  = 4;
  localparam int RW  = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          ele_valid;
  logic [W-1:0]  eleOut;
  logic [AW-1:0] rd_addr;
  logic [W-1:0]  rd_data;
  logic          busy;
  logic          done;
  logic [RW-1:0] row;
  logic [RW-1:0] col;
  logic          overflow;

  always #5 clk = ~clk;

  matrix_result_collector #(.DIM(DIM), .W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .ele_valid (ele_valid),
    .eleOut    (eleOut),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .busy      (busy),
    .done      (done),
    .row       (row),
    .col       (col),
    .overflow  (overflow)
  );

  typedef struct {
    logic         busy;
    logic         done;
    int           row;
    int           col;
    logic         ovf;
    logic         rd_known;
    logic [W-1:0] rd;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: capture progress is an element count; row/col derive
  // from it by division, the buffer is a plain array.
  logic [W-1:0] m_mem [N];
  bit           m_known [N];
  bit           m_cap, m_done, m_ovf;
  int           m_idx;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(input bit r, input bit s, input bit v, input logic [W-1:0] d, input int a);
    exp_t e;
    #1;
    reset = r; start = s; ele_valid = v; eleOut = d; rd_addr = AW'(a);
    @(posedge clk);
    if (!r) begin
      m_cap = 0; m_done = 0; m_idx = 0; m_ovf = 0;
      e.rd = '0; e.rd_known = 1'b1;
    end else begin
      e.rd_known = (a < N) ? m_known[a] : 1'b1;
      e.rd       = (a < N) ? m_mem[a] : '0;
      if (m_done) begin
        m_done = 0;
        if (v) m_ovf = 1;
      end else if (m_cap) begin
        if (v) begin
          m_mem[m_idx]   = d;
          m_known[m_idx] = 1;
          m_idx++;
          if (m_idx == N) begin
            m_idx = 0; m_cap = 0; m_done = 1;
          end
        end
      end else if (s) begin
        m_idx = 0; m_ovf = 0; m_cap = 1;
      end else if (v) begin
        m_ovf = 1;
      end
    end
    e.busy = m_cap;
    e.done = m_done;
    e.row  = m_idx / DIM;
    e.col  = m_idx % DIM;
    e.ovf  = m_ovf;
    q.push_back(e);
  endtask

  task automatic read_all();
    for (int a = 0; a < N; a++) cyc(1, 0, 0, '0, a);
  endtask

  // Monitor: compares every post-edge DUT state against the queued model.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("busy", W'(busy), W'(e.busy));
        chk("done", W'(done), W'(e.done));
        chk("row", W'(row), W'(e.row));
        chk("col", W'(col), W'(e.col));
        chk("overflow", W'(overflow), W'(e.ovf));
        if (e.rd_known) chk("rd_data", rd_data, e.rd);
      end
    end
  end

  initial begin
    int k;
    for (int i = 0; i < N; i++) begin
      m_mem[i] = '0; m_known[i] = 0;
    end
    m_cap = 0; m_done = 0; m_ovf = 0; m_idx = 0;
    reset = 0; start = 0; ele_valid = 0; eleOut = '0; rd_addr = '0;

    repeat (5) cyc(0, 0, 0, '0, 0);

    // Full back-to-back capture 1..16, then readback.
    cyc(1, 1, 0, '0, 0);
    for (int i = 1; i <= N; i++) cyc(1, 0, 1, W'(i), 0);
    repeat (2) cyc(1, 0, 0, '0, 0);
    read_all();

    // Random data with random gaps, to disturb contents before the gapped run.
    cyc(1, 1, 0, '0, 0);
    k = 0;
    while (k < N) begin
      if ($urandom_range(0, 2) != 0) begin
        cyc(1, 0, 1, $urandom, $urandom_range(0, N-1));
        k++;
      end else begin
        cyc(1, 0, 0, $urandom, $urandom_range(0, N-1));
      end
    end
    cyc(1, 0, 0, '0, 0);

    // Gapped capture 1..16, valid pattern 1,0,0.
    cyc(1, 1, 0, '0, 0);
    k = 1;
    for (int step = 0; k <= N; step++) begin
      if (step % 3 == 0) begin
        cyc(1, 0, 1, W'(k), 0);
        k++;
      end else begin
        cyc(1, 0, 0, 32'h5555_0000 + W'(step), 0);
      end
    end
    cyc(1, 0, 0, '0, 0);
    read_all();

    // Overflow in IDLE, buffer untouched, cleared by next start.
    cyc(1, 0, 1, 32'hDEAD_BEEF, 0);
    read_all();
    cyc(1, 1, 0, '0, 0);
    for (int i = 0; i < N; i++) cyc(1, 0, 1, 32'h1000 + W'(i), i);
    repeat (2) cyc(1, 0, 0, '0, 0);

    // start and ele_valid together in IDLE, then 7 writes with concurrent
    // same-address reads, then reset mid-capture.
    cyc(1, 1, 1, 32'h0BAD_0BAD, 0);
    for (int i = 0; i < 7; i++) cyc(1, 0, 1, 32'h2000 + W'(i), i);
    cyc(0, 0, 1, 32'hFFFF_FFFF, 7);
    repeat (3) cyc(1, 0, 0, '0, 0);
    read_all();

    // Randomised traffic with occasional reset.
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 59) != 0), ($urandom_range(0, 7) == 0),
          $urandom_range(0, 1) == 1, $urandom, $urandom_range(0, N-1));
    end
    cyc(1, 0, 0, '0, 0);
    read_all();

    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
